// File: rtl/shift_concat_unit_pkg.sv
// +-----------------------------------------------------------------------------
// | shift_concat_unit_pkg : default geometry shared by the shift/concat block
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package shift_concat_unit_pkg;

  localparam int SC_WIDTH = 4;
  localparam int SC_SHAMT = 2;
  localparam int SC_REP   = 2;

endpackage : shift_concat_unit_pkg

`default_nettype wire

// File: rtl/shift_concat_core.sv
// +-----------------------------------------------------------------------------
// | shift_concat_core : combinational shift, concatenation and replication
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module shift_concat_core
  import shift_concat_unit_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int SHAMT = SC_SHAMT,
  parameter int REP   = SC_REP
) (
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     yl_lsh_o,
  output logic [WIDTH-1:0]     ya_lsh_o,
  output logic [WIDTH-1:0]     yl_rsh_o,
  output logic [WIDTH-1:0]     ya_rsh_o,
  output logic [2*WIDTH-1:0]   y_con_o,
  output logic [REP*WIDTH-1:0] y_rep_o
);

  logic [WIDTH-1:0] w_lsh;

  // Arithmetic left shift has no sign handling, so both left results share one shifter.
  assign w_lsh    = a_i << SHAMT;
  assign yl_lsh_o = w_lsh;
  assign ya_lsh_o = w_lsh;
  assign yl_rsh_o = b_i >> SHAMT;
  assign ya_rsh_o = $signed(b_i) >>> SHAMT;
  assign y_con_o  = {b_i, a_i};
  assign y_rep_o  = {REP{a_i}};

endmodule : shift_concat_core

`default_nettype wire

// File: rtl/shift_concat_unit.sv
// +-----------------------------------------------------------------------------
// | shift_concat_unit : one-stage registered wrapper around shift_concat_core
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module shift_concat_unit
  import shift_concat_unit_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int SHAMT = SC_SHAMT,
  parameter int REP   = SC_REP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     yl_lsh,
  output logic [WIDTH-1:0]     ya_lsh,
  output logic [WIDTH-1:0]     yl_rsh,
  output logic [WIDTH-1:0]     ya_rsh,
  output logic [2*WIDTH-1:0]   y_con,
  output logic [REP*WIDTH-1:0] y_rep
);

  logic [WIDTH-1:0]     yl_lsh_d, ya_lsh_d, yl_rsh_d, ya_rsh_d;
  logic [2*WIDTH-1:0]   y_con_d;
  logic [REP*WIDTH-1:0] y_rep_d;

  logic                 out_valid_q;
  logic [WIDTH-1:0]     yl_lsh_q, ya_lsh_q, yl_rsh_q, ya_rsh_q;
  logic [2*WIDTH-1:0]   y_con_q;
  logic [REP*WIDTH-1:0] y_rep_q;

  shift_concat_core #(
    .WIDTH (WIDTH),
    .SHAMT (SHAMT),
    .REP   (REP)
  ) u_core (
    .a_i      (a),
    .b_i      (b),
    .yl_lsh_o (yl_lsh_d),
    .ya_lsh_o (ya_lsh_d),
    .yl_rsh_o (yl_rsh_d),
    .ya_rsh_o (ya_rsh_d),
    .y_con_o  (y_con_d),
    .y_rep_o  (y_rep_d)
  );

  // Results load every cycle; only out_valid says whether they mean anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      yl_lsh_q    <= '0;
      ya_lsh_q    <= '0;
      yl_rsh_q    <= '0;
      ya_rsh_q    <= '0;
      y_con_q     <= '0;
      y_rep_q     <= '0;
    end else begin
      out_valid_q <= in_valid;
      yl_lsh_q    <= yl_lsh_d;
      ya_lsh_q    <= ya_lsh_d;
      yl_rsh_q    <= yl_rsh_d;
      ya_rsh_q    <= ya_rsh_d;
      y_con_q     <= y_con_d;
      y_rep_q     <= y_rep_d;
    end
  end

  assign out_valid = out_valid_q;
  assign yl_lsh    = yl_lsh_q;
  assign ya_lsh    = ya_lsh_q;
  assign yl_rsh    = yl_rsh_q;
  assign ya_rsh    = ya_rsh_q;
  assign y_con     = y_con_q;
  assign y_rep     = y_rep_q;

endmodule : shift_concat_unit

`default_nettype wire

// File: tb/tb_shift_concat_unit.sv
// +-----------------------------------------------------------------------------
// | tb_shift_concat_unit : directed self-checking bench for shift_concat_unit
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_shift_concat_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic       out_valid;
  logic [3:0] yl_lsh, ya_lsh, yl_rsh, ya_rsh;
  logic [7:0] y_con, y_rep;

  int checks = 0;
  int errors = 0;

  shift_concat_unit #(.WIDTH(4), .SHAMT(2), .REP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .yl_lsh    (yl_lsh),
    .ya_lsh    (ya_lsh),
    .yl_rsh    (yl_rsh),
    .ya_rsh    (ya_rsh),
    .y_con     (y_con),
    .y_rep     (y_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a pair at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic v);
    @(negedge clk);
    a = av; b = bv; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] ll, input logic [3:0] lr,
                           input logic [3:0] ar, input logic [7:0] con,
                           input logic [7:0] rep, input logic vld);
    check({tag, ".yl_lsh"}, 16'(yl_lsh), 16'(ll));
    check({tag, ".ya_lsh"}, 16'(ya_lsh), 16'(ll));
    check({tag, ".yl_rsh"}, 16'(yl_rsh), 16'(lr));
    check({tag, ".ya_rsh"}, 16'(ya_rsh), 16'(ar));
    check({tag, ".y_con"},  16'(y_con),  16'(con));
    check({tag, ".y_rep"},  16'(y_rep),  16'(rep));
    check({tag, ".out_valid"}, 16'(out_valid), 16'(vld));
  endtask

  // Arithmetic reference for WIDTH=4, SHAMT=2, REP=2.
  task automatic check_model(input string tag, input int av, input int bv, input logic vld);
    int ll, lr, ar;
    ll = (av * 4) % 16;
    lr = bv / 4;
    ar = (bv >= 8) ? (lr + 12) : lr;
    check_all(tag, 4'(ll), 4'(lr), 4'(ar), 8'(bv * 16 + av), 8'(av * 17), vld);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    #1;
    check_all("reset_init", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
    #20;
    rst_n = 1'b1;

    step(4'b1010, 4'b1001, 1'b1);
    check_all("v1", 4'b1000, 4'b0010, 4'b1110, 8'b10011010, 8'b10101010, 1'b1);
    step(4'b1111, 4'b1100, 1'b1);
    check_all("v2", 4'b1100, 4'b0011, 4'b1111, 8'b11001111, 8'b11111111, 1'b1);
    step(4'b1101, 4'b1011, 1'b1);
    check_all("v3", 4'b0100, 4'b0010, 4'b1110, 8'b10111101, 8'b11011101, 1'b1);
    step(4'b0011, 4'b0110, 1'b1);
    check_all("v4_posb", 4'b1100, 4'b0001, 4'b0001, 8'b01100011, 8'b00110011, 1'b1);

    // Asynchronous reset mid-stream with nonzero outputs, away from any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
    step(4'b1111, 4'b1111, 1'b1);
    check_all("held_reset", 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0001, 4'b1000, 1'b0);
    check_all("post_rel_idle", 4'b0100, 4'b0010, 4'b1110, 8'b10000001, 8'b00010001, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(4'(10 + i), 4'(9 + (i % 4)), 1'b1);
      check_model($sformatf("sweep%0d", i), 10 + i, 9 + (i % 4), 1'b1);
    end

    step(4'd7, 4'd12, 1'b0);
    check_model("drop_valid", 7, 12, 1'b0);
    step(4'd12, 4'd10, 1'b1);
    check_model("resume", 12, 10, 1'b1);
    step(4'd0, 4'd15, 1'b1);
    check_model("edge_zero_a", 0, 15, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_concat_unit

`default_nettype wire
